// File: rtl/ahbl_timer.sv
// AHB-Lite timer slave: 32-bit down-counter with prescaler, one-shot/periodic modes
// and a level interrupt. Zero wait states; register map decoded on HADDR[4:2].
module ahbl_timer #(
  parameter int unsigned PRE_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_PRE    = 3'd1,
    OFF_LOAD   = 3'd2,
    OFF_COUNT  = 3'd3,
    OFF_STATUS = 3'd4,
    OFF_RSV5   = 3'd5,
    OFF_RSV6   = 3'd6,
    OFF_RSV7   = 3'd7
  } reg_off_e;

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  // Address-phase capture
  logic     dp_valid;
  logic     dp_write;
  logic     dp_size_ok;
  reg_off_e dp_off;

  // Architectural state
  logic             ctrl_en;
  logic             ctrl_per;
  logic             ctrl_ie;
  logic [PRE_W-1:0] pre;
  logic [31:0]      load;
  logic [31:0]      count;
  logic             exp_flag;
  logic [PRE_W-1:0] pcnt;

  logic accept;
  logic wr;
  logic wr_ctrl, wr_pre, wr_load, wr_count, wr_status;
  logic tick;
  logic expire;
  logic unused_bits;

  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_size_ok <= 1'b0;
      dp_off     <= OFF_CTRL;
    end else begin
      dp_valid   <= accept;
      dp_write   <= HWRITE;
      dp_size_ok <= (HSIZE == 3'b010);
      dp_off     <= reg_off_e'(HADDR[4:2]);
    end
  end

  assign wr        = dp_valid & dp_write & dp_size_ok;
  assign wr_ctrl   = wr & (dp_off == OFF_CTRL);
  assign wr_pre    = wr & (dp_off == OFF_PRE);
  assign wr_load   = wr & (dp_off == OFF_LOAD);
  assign wr_count  = wr & (dp_off == OFF_COUNT);
  assign wr_status = wr & (dp_off == OFF_STATUS);

  assign tick   = ctrl_en & (pcnt == pre);
  assign expire = tick & (count == '0);

  // Timer events are applied first; bus writes later in the block override them.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en  <= 1'b0;
      ctrl_per <= 1'b0;
      ctrl_ie  <= 1'b0;
      pre      <= '0;
      load     <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      pcnt     <= '0;
    end else begin
      if (ctrl_en) pcnt <= tick ? '0 : pcnt + PRE_ONE;
      else         pcnt <= '0;

      if (tick) begin
        if (count != '0)   count   <= count - 32'd1;
        else if (ctrl_per) count   <= load;
        else               ctrl_en <= 1'b0;
      end

      // Set wins over write-1-to-clear
      exp_flag <= (exp_flag & ~(wr_status & HWDATA[0])) | expire;

      if (wr_ctrl) begin
        ctrl_en  <= HWDATA[0];
        ctrl_per <= HWDATA[1];
        ctrl_ie  <= HWDATA[2];
        if (!ctrl_en && HWDATA[0]) begin
          count <= load;
          pcnt  <= '0;
        end
      end
      if (wr_pre)   pre   <= HWDATA[PRE_W-1:0];
      if (wr_load)  load  <= HWDATA;
      if (wr_count) count <= HWDATA;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_off)
        OFF_CTRL:   HRDATA[2:0]       = {ctrl_ie, ctrl_per, ctrl_en};
        OFF_PRE:    HRDATA[PRE_W-1:0] = pre;
        OFF_LOAD:   HRDATA            = load;
        OFF_COUNT:  HRDATA            = count;
        OFF_STATUS: HRDATA[0]         = exp_flag;
        default:    HRDATA            = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign IRQ       = exp_flag & ctrl_ie;

endmodule
